// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the lsu data-memory port between the M-stage CPU
// access and a word-burst debug/loader master. Debug bursts are sequenced
// beat by beat; the CPU is stalled while a beat owns the port, and counters
// bound how long either side can be starved by the other.
module dmem_arbiter #(
  parameter int MAX_DBG_WAIT  = 3,
  parameter int CPU_MAX_STALL = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  // CPU (M stage) side
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [11:0] cpu_addr_i,
  input  logic [3:0]  cpu_be_i,
  input  logic [31:0] cpu_wdata_i,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_stall_o,
  // debug / loader side
  input  logic        dbg_req_i,
  input  logic        dbg_we_i,
  input  logic [11:0] dbg_addr_i,
  input  logic [3:0]  dbg_len_i,
  input  logic [31:0] dbg_wdata_i,
  output logic        dbg_gnt_o,
  output logic        dbg_beat_o,
  output logic        dbg_rvalid_o,
  output logic [31:0] dbg_rdata_o,
  output logic        dbg_done_o,
  // lsu memory port
  output logic        mem_st_en_o,
  output logic [11:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_st_data_o,
  input  logic [31:0] mem_ld_data_i
);

  // Counter widths leave headroom so a parameter of 0 still gets one bit.
  localparam int WAIT_W  = $clog2(MAX_DBG_WAIT + 2);
  localparam int STALL_W = $clog2(CPU_MAX_STALL + 2);

  localparam logic [WAIT_W-1:0]  WAIT_LIMIT  = WAIT_W'(MAX_DBG_WAIT);
  localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(CPU_MAX_STALL);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t               state;
  logic [WAIT_W-1:0]    wait_cnt;
  logic [STALL_W-1:0]   stall_cnt;
  logic [3:0]           beat_cnt;
  logic                 we_q;
  logic [11:0]          addr_q;
  logic [3:0]           len_q;

  logic                 accept;
  logic                 cpu_slot;
  logic                 beat;
  logic                 last_beat;
  logic                 rd_beat;
  logic [11:0]          beat_addr;

  // Word address of a burst beat; the 12-bit sum wraps at the top of memory.
  function automatic logic [11:0] burst_addr(input logic [11:0] base,
                                             input logic [3:0]  idx);
    return base + {6'd0, idx, 2'b00};
  endfunction

  // Arbitration decisions, derived only from state, counters and cpu_req_i
  // (plus dbg_req_i for the grant) so the stall never depends on dbg_* inputs.
  always_comb begin
    accept    = (state == IDLE) & dbg_req_i &
                (~cpu_req_i | (wait_cnt == WAIT_LIMIT));
    cpu_slot  = (state == BURST) & cpu_req_i & (stall_cnt == STALL_LIMIT);
    beat      = (state == BURST) & ~cpu_slot;
    last_beat = beat & (beat_cnt == len_q);
    rd_beat   = beat & ~we_q;
    beat_addr = burst_addr(addr_q, beat_cnt);
  end

  // Memory port mux: debug owns the port on beat cycles, the CPU otherwise
  // (IDLE, the accept cycle and inserted CPU slots).
  always_comb begin
    if (beat) begin
      mem_st_en_o   = we_q;
      mem_addr_o    = beat_addr;
      mem_be_o      = 4'hF;
      mem_st_data_o = dbg_wdata_i;
    end else begin
      mem_st_en_o   = cpu_req_i & cpu_we_i;
      mem_addr_o    = cpu_addr_i;
      mem_be_o      = cpu_be_i;
      mem_st_data_o = cpu_wdata_i;
    end
  end

  // Handshake and stall outputs; CPU load data comes straight from memory.
  always_comb begin
    dbg_gnt_o   = accept;
    dbg_beat_o  = beat;
    cpu_stall_o = beat & cpu_req_i;
    cpu_rdata_o = mem_ld_data_i;
  end

  // Arbiter FSM with its counters, latched burst descriptor and the
  // registered read-data / completion outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      stall_cnt    <= '0;
      beat_cnt     <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      len_q        <= '0;
      dbg_rvalid_o <= 1'b0;
      dbg_rdata_o  <= '0;
      dbg_done_o   <= 1'b0;
    end else begin
      // Read beats return their data one cycle later; done follows the
      // final beat so it lines up with the last rvalid of a read burst.
      dbg_rvalid_o <= rd_beat;
      dbg_done_o   <= last_beat;
      if (rd_beat) begin
        dbg_rdata_o <= mem_ld_data_i;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            we_q      <= dbg_we_i;
            addr_q    <= dbg_addr_i;
            len_q     <= dbg_len_i;
            beat_cnt  <= '0;
            wait_cnt  <= '0;
            stall_cnt <= '0;
            state     <= BURST;
          end else if (dbg_req_i & cpu_req_i & (wait_cnt < WAIT_LIMIT)) begin
            wait_cnt <= wait_cnt + 1'b1;
          end else if (!dbg_req_i) begin
            wait_cnt <= '0;
          end
        end

        BURST: begin
          if (cpu_slot) begin
            // The CPU gets this cycle; the burst pauses without advancing.
            stall_cnt <= '0;
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
            if (cpu_req_i) begin
              stall_cnt <= stall_cnt + 1'b1;
            end else begin
              stall_cnt <= '0;
            end
            if (last_beat) begin
              state <= IDLE;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios followed by randomized
// traffic, every cycle compared against a transaction-level reference model
// (queue of pending beat addresses plus starvation counters).
module tb_dmem_arbiter;

  localparam int MAX_DBG_WAIT  = 3;
  localparam int CPU_MAX_STALL = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we;
  logic [11:0] cpu_addr;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dbg_req, dbg_we;
  logic [11:0] dbg_addr;
  logic [3:0]  dbg_len;
  logic [31:0] dbg_wdata;
  logic        dbg_gnt, dbg_beat, dbg_rvalid, dbg_done;
  logic [31:0] dbg_rdata;
  logic        mem_st_en;
  logic [11:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_st_data, mem_ld_data;

  logic [31:0] mem [0:1023];
  assign mem_ld_data = mem[mem_addr[11:2]];

  always #5 clk = ~clk;

  dmem_arbiter #(
    .MAX_DBG_WAIT (MAX_DBG_WAIT),
    .CPU_MAX_STALL(CPU_MAX_STALL)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cpu_req_i    (cpu_req),
    .cpu_we_i     (cpu_we),
    .cpu_addr_i   (cpu_addr),
    .cpu_be_i     (cpu_be),
    .cpu_wdata_i  (cpu_wdata),
    .cpu_rdata_o  (cpu_rdata),
    .cpu_stall_o  (cpu_stall),
    .dbg_req_i    (dbg_req),
    .dbg_we_i     (dbg_we),
    .dbg_addr_i   (dbg_addr),
    .dbg_len_i    (dbg_len),
    .dbg_wdata_i  (dbg_wdata),
    .dbg_gnt_o    (dbg_gnt),
    .dbg_beat_o   (dbg_beat),
    .dbg_rvalid_o (dbg_rvalid),
    .dbg_rdata_o  (dbg_rdata),
    .dbg_done_o   (dbg_done),
    .mem_st_en_o  (mem_st_en),
    .mem_addr_o   (mem_addr),
    .mem_be_o     (mem_be),
    .mem_st_data_o(mem_st_data),
    .mem_ld_data_i(mem_ld_data)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [11:0] bq[$];
  logic        bw;
  int          starve;
  int          run;
  logic        m_rvalid, m_done;
  logic [31:0] m_rdata;

  // Last observed DUT outputs, for directed checks
  logic        o_gnt, o_beat, o_stall, o_done, o_rvalid, o_en;
  logic [11:0] o_addr;
  logic [31:0] o_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    bq.delete();
    bw = 1'b0;
    starve = 0;
    run = 0;
    m_rvalid = 1'b0;
    m_done = 1'b0;
    m_rdata = '0;
  endtask

  task automatic zero_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_be = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_len = '0; dbg_wdata = '0;
  endtask

  // One clock cycle: called at a falling edge with inputs already set.
  task automatic tick();
    logic        e_gnt, e_beat, e_slot, e_stall, e_en;
    logic [11:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wd, rd;
    logic        w_en;
    logic [11:0] w_addr;
    logic [3:0]  w_be;
    logic [31:0] w_d;
    #1;
    e_gnt = 0; e_beat = 0; e_slot = 0; e_stall = 0;
    if (bq.size() == 0)
      e_gnt = dbg_req && (!cpu_req || starve == MAX_DBG_WAIT);
    else if (cpu_req && run == CPU_MAX_STALL)
      e_slot = 1;
    else begin
      e_beat = 1;
      e_stall = cpu_req;
    end
    if (e_beat) begin
      e_addr = bq[0]; e_be = 4'hF; e_wd = dbg_wdata; e_en = bw;
    end else begin
      e_addr = cpu_addr; e_be = cpu_be; e_wd = cpu_wdata; e_en = cpu_req && cpu_we;
    end
    rd = mem[e_addr[11:2]];
    chk("gnt", dbg_gnt, e_gnt);
    chk("beat", dbg_beat, e_beat);
    chk("stall", cpu_stall, e_stall);
    chk("st_en", mem_st_en, e_en);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_be", mem_be, e_be);
    chk("st_data", mem_st_data, e_wd);
    chk("cpu_rdata", cpu_rdata, rd);
    chk("rvalid", dbg_rvalid, m_rvalid);
    chk("done", dbg_done, m_done);
    chk("rdata", dbg_rdata, m_rdata);
    o_gnt = dbg_gnt; o_beat = dbg_beat; o_stall = cpu_stall; o_done = dbg_done;
    o_rvalid = dbg_rvalid; o_en = mem_st_en; o_addr = mem_addr; o_rdata = dbg_rdata;
    w_en = mem_st_en; w_addr = mem_addr; w_be = mem_be; w_d = mem_st_data;
    @(posedge clk);
    if (w_en)
      for (int b = 0; b < 4; b++)
        if (w_be[b]) mem[w_addr[11:2]][8*b +: 8] = w_d[8*b +: 8];
    m_rvalid = e_beat && !bw;
    if (m_rvalid) m_rdata = rd;
    m_done = e_beat && (bq.size() == 1);
    if (e_beat) begin
      void'(bq.pop_front());
      run = cpu_req ? run + 1 : 0;
    end else if (e_slot) begin
      run = 0;
    end else if (e_gnt) begin
      for (int i = 0; i <= int'(dbg_len); i++)
        bq.push_back(dbg_addr + 12'(4 * i));
      bw = dbg_we;
      starve = 0;
      run = 0;
    end else if (dbg_req && cpu_req && starve < MAX_DBG_WAIT) begin
      starve++;
    end else if (!dbg_req) begin
      starve = 0;
    end
    @(negedge clk);
  endtask

  logic        r_beat [0:7];
  logic        r_rv   [0:7];
  logic        r_done [0:7];
  logic [11:0] r_addr [0:7];
  logic [31:0] r_rd   [0:7];
  logic [11:0] wrap_exp [0:3];
  int n, stalls, slots, beats, dones, done_cyc;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    zero_inputs();
    model_reset();
    rst_n = 0;
    #1;
    chk("rst_rvalid", dbg_rvalid, 0);
    chk("rst_done", dbg_done, 0);
    chk("rst_rdata", dbg_rdata, 0);
    chk("rst_stall", cpu_stall, 0);
    chk("rst_beat", dbg_beat, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;

    // Plain CPU store in IDLE
    cpu_req = 1; cpu_we = 1; cpu_addr = 12'h010; cpu_be = 4'hF; cpu_wdata = 32'hDEADBEEF;
    tick();
    chk("idle_st_en", o_en, 1);
    chk("idle_addr", o_addr, 12'h010);
    chk("idle_stall", o_stall, 0);
    chk("idle_gnt", o_gnt, 0);
    chk("idle_memwr", mem[4], 32'hDEADBEEF);
    zero_inputs();
    tick();

    // Debug read burst, CPU idle
    dbg_req = 1; dbg_we = 0; dbg_addr = 12'h100; dbg_len = 4'd3;
    tick();
    chk("rb_gnt", o_gnt, 1);
    dbg_req = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      r_beat[k] = o_beat; r_rv[k] = o_rvalid; r_done[k] = o_done;
      r_addr[k] = o_addr; r_rd[k] = o_rdata;
    end
    for (int k = 1; k <= 6; k++) begin
      chk($sformatf("rb_beat%0d", k), r_beat[k], (k <= 4));
      chk($sformatf("rb_rvalid%0d", k), r_rv[k], (k >= 2 && k <= 5));
      chk($sformatf("rb_done%0d", k), r_done[k], (k == 5));
    end
    for (int k = 1; k <= 4; k++)
      chk($sformatf("rb_addr%0d", k), r_addr[k], 12'h100 + 12'(4 * (k - 1)));
    for (int k = 2; k <= 5; k++)
      chk($sformatf("rb_data%0d", k), r_rd[k], mem[12'h100 / 4 + k - 2]);

    // Debug starved by continuous CPU traffic
    cpu_req = 1; cpu_we = 0; cpu_addr = 12'h020; cpu_be = 4'hF;
    dbg_req = 1; dbg_we = 0; dbg_addr = 12'h200; dbg_len = 4'd0;
    n = 0;
    for (int k = 1; k <= 10 && n == 0; k++) begin
      tick();
      if (o_gnt) n = k;
    end
    chk("starve_gnt_cycle", n, 4);
    zero_inputs();
    repeat (4) tick();

    // 16-beat write burst with CPU requesting throughout
    dbg_req = 1; dbg_we = 1; dbg_addr = 12'h300; dbg_len = 4'd15;
    tick();
    chk("slot_gnt", o_gnt, 1);
    dbg_req = 0;
    cpu_req = 1; cpu_we = 1; cpu_addr = 12'h040; cpu_be = 4'h3; cpu_wdata = $urandom;
    stalls = 0; slots = 0; beats = 0; dones = 0; done_cyc = 0;
    for (int k = 1; k <= 25; k++) begin
      dbg_wdata = $urandom;
      tick();
      if (o_stall) stalls++;
      if (o_beat) beats++;
      if (o_done) begin dones++; done_cyc = k; end
      if (k < 20 && !o_beat) begin
        slots++;
        chk("slot_addr", o_addr, 12'h040);
      end
    end
    chk("slot_stalls", stalls, 16);
    chk("slot_beats", beats, 16);
    chk("slot_slots", slots, 3);
    chk("slot_dones", dones, 1);
    chk("slot_done_cycle", done_cyc, 20);
    zero_inputs();
    tick();

    // Address wrap at the top of memory
    wrap_exp[0] = 12'hFF8; wrap_exp[1] = 12'hFFC; wrap_exp[2] = 12'h000; wrap_exp[3] = 12'h004;
    dbg_req = 1; dbg_we = 0; dbg_addr = 12'hFF8; dbg_len = 4'd3;
    tick();
    dbg_req = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("wrap_addr%0d", k), o_addr, wrap_exp[k]);
    end
    repeat (2) tick();

    // Reset in the middle of a burst
    dbg_req = 1; dbg_we = 0; dbg_addr = 12'h080; dbg_len = 4'd7;
    tick();
    dbg_req = 0;
    repeat (2) tick();
    #2;
    rst_n = 0;
    #1;
    chk("mrst_beat", dbg_beat, 0);
    chk("mrst_rvalid", dbg_rvalid, 0);
    chk("mrst_done", dbg_done, 0);
    chk("mrst_rdata", dbg_rdata, 0);
    chk("mrst_stall", cpu_stall, 0);
    chk("mrst_st_en", mem_st_en, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    dones = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (o_done || o_rvalid) dones++;
    end
    chk("mrst_no_done", dones, 0);
    dbg_req = 1; dbg_we = 1; dbg_addr = 12'h0C0; dbg_len = 4'd1;
    tick();
    chk("mrst_regnt", o_gnt, 1);
    dbg_req = 0;
    repeat (4) tick();

    // Randomized traffic with varying CPU load
    for (int k = 0; k < 3000; k++) begin
      int load;
      load = (k / 250) % 4;
      cpu_req   = ($urandom_range(0, 3) < load + 0) || (load == 3);
      cpu_we    = $urandom_range(0, 1);
      cpu_addr  = 12'($urandom);
      cpu_be    = 4'($urandom);
      cpu_wdata = $urandom;
      dbg_wdata = $urandom;
      if (!dbg_req && $urandom_range(0, 5) == 0) begin
        dbg_req  = 1;
        dbg_we   = $urandom_range(0, 1);
        dbg_addr = 12'($urandom) & 12'hFFC;
        dbg_len  = 4'($urandom);
      end
      tick();
      if (o_gnt) dbg_req = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port of the lsu between two requesters: the pipeline memory stage (CPU) and a debug/loader master that issues word bursts.
- Sits between the M-stage pipeline register and the lsu.
- Sequences debug bursts beat by beat and produces a stall for the pipeline whenever the CPU is denied the port.
- Bounds starvation in both directions with wait/stall counters.

Parameters:
- MAX_DBG_WAIT, 3: consecutive IDLE cycles a pending debug request may be blocked by CPU traffic before it is forced in.
- CPU_MAX_STALL, 4: consecutive CPU stall cycles during a burst before one CPU slot is inserted.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- cpu_req_i  in  1  M stage performs load/store this cycle
- cpu_we_i  in  1  CPU store
- cpu_addr_i  in  12  CPU byte address
- cpu_be_i  in  4  CPU byte enables
- cpu_wdata_i  in  32  CPU store data
- cpu_rdata_o  out  32  CPU load data
- cpu_stall_o  out  1  freeze F/D/E/M and hold M inputs
- dbg_req_i  in  1  debug burst request, held until dbg_gnt_o
- dbg_we_i  in  1  burst is write
- dbg_addr_i  in  12  burst start address, word aligned
- dbg_len_i  in  4  beats minus one (1..16 beats)
- dbg_wdata_i  in  32  write data for the current beat
- dbg_gnt_o  out  1  one-cycle burst-accept pulse
- dbg_beat_o  out  1  current burst beat issued to memory this cycle
- dbg_rvalid_o  out  1  dbg_rdata_o valid
- dbg_rdata_o  out  32  registered read beat
- dbg_done_o  out  1  one-cycle pulse after the last beat
- mem_st_en_o  out  1  memory store enable
- mem_addr_o  out  12  memory address
- mem_be_o  out  4  memory byte enables
- mem_st_data_o  out  32  memory store data
- mem_ld_data_i  in  32  memory load data, combinational from mem_addr_o

Behaviour:
- Clock and reset: one clock, clk_i. rst_ni is asynchronous, active-low.
- Reset state: IDLE, all counters 0, all registered outputs 0.
- Reset mid-burst aborts the burst. No dbg_done_o or dbg_rvalid_o is produced.
- FSM states: IDLE, BURST.
- IDLE, memory port: mux selects CPU. mem_st_en_o = cpu_req_i & cpu_we_i. cpu_stall_o = 0.
- IDLE, debug pending and blocked: if dbg_req_i & cpu_req_i & wait_cnt < MAX_DBG_WAIT, then wait_cnt++.
- IDLE, burst accept: if dbg_req_i & (!cpu_req_i | wait_cnt == MAX_DBG_WAIT):
  - pulse dbg_gnt_o;
  - latch we/addr/len;
  - clear beat_cnt, wait_cnt, stall_cnt;
  - go to BURST.
  - The CPU still owns the port in the accept cycle.
- IDLE, no debug request: wait_cnt clears to 0.
- BURST, debug beat cycle: applies when !cpu_req_i, or when cpu_req_i & stall_cnt < CPU_MAX_STALL.
  - mux selects debug; mem_addr_o = addr_q + 4*beat_cnt, 12-bit wrap at 4096.
  - mem_be_o = 4'hF; mem_st_data_o = dbg_wdata_i; mem_st_en_o = we_q.
  - dbg_beat_o = 1; beat_cnt++.
  - cpu_stall_o = cpu_req_i; stall_cnt++ when cpu_req_i.
- BURST, CPU slot cycle: applies when cpu_req_i & stall_cnt == CPU_MAX_STALL.
  - mux selects CPU; cpu_stall_o = 0; dbg_beat_o = 0; stall_cnt clears; beat_cnt holds.
- BURST, CPU idle: stall_cnt clears on any cycle with !cpu_req_i.
- Read beats: on a read beat, dbg_rdata_o <= mem_ld_data_i and dbg_rvalid_o = 1 in the following cycle. Otherwise dbg_rvalid_o = 0.
- Burst end: the beat with beat_cnt == len_q is the last.
  - Next cycle: dbg_done_o = 1, state returns to IDLE.
  - dbg_done_o coincides with the final dbg_rvalid_o on reads.
- dbg_req_i asserted during BURST is ignored until IDLE. Back-to-back bursts need at least one IDLE cycle.
- cpu_rdata_o = mem_ld_data_i combinationally. It is meaningful only when cpu_req_i & !cpu_stall_o.
- Stall is combinational from cpu_req_i and registered state. No combinational path from dbg_* to cpu_stall_o.
- Latency:
  - CPU: 0 cycles in IDLE or in a slot.
  - Debug: first beat 1 cycle after dbg_gnt_o; N beats complete in N cycles plus inserted CPU slots.

Test Plan:
- Idle CPU traffic: cpu_req=1, we=1, addr=0x010, be=F, wdata=0xDEADBEEF, dbg_req=0 -> mem_st_en=1, mem_addr=0x010, cpu_stall=0, no dbg_gnt.
- Debug read burst: dbg_req, we=0, addr=0x100, len=3, CPU idle -> gnt in cycle 0; beats at 0x100/104/108/10C in cycles 1-4; rvalid in cycles 2-5; done in cycle 5.
- Starvation of debug: cpu_req held high, dbg_req high -> gnt on the 4th IDLE cycle (wait_cnt reaches 3).
- CPU slot insertion: 16-beat write burst with cpu_req held high -> cpu_stall high 4 cycles, low 1 cycle (CPU access at cpu_addr, beat paused), pattern repeats; burst takes 20 cycles; done once.
- Wrap-around: addr=0xFF8, len=3 -> addresses 0xFF8, 0xFFC, 0x000, 0x004.
- Reset mid-burst: assert rst_ni low at beat 2 -> all outputs 0 immediately, no done; after release, a new request is granted normally.
